// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the convolution pixel source, frame_sequencer and the TFT controller.
// master = sequencer side, slave = the surrounding pixel source / display pair.
`timescale 1ns/1ps
interface frame_sequencer_if;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        disp_valid;
  logic [23:0] disp_data;
  logic        disp_done;

  modport master (
    input  pix_valid, pix_data, disp_done,
    output pix_ready, disp_valid, disp_data
  );

  modport slave (
    output pix_valid, pix_data, disp_done,
    input  pix_ready, disp_valid, disp_data
  );
endinterface

// File: rtl/frame_sequencer.sv
// Hands convolution pixels one at a time to the TFT controller and tracks the frame position.
// Optional macro FRAME_SKIP_EN: odd frames are consumed and counted but never displayed.
`timescale 1ns/1ps
module frame_sequencer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              init_comp,
  input  logic              vs,
  input  logic              clr_err,
  frame_sequencer_if.master bus,
  output logic              frame_active,
  output logic [8:0]        pix_cnt,
  output logic [8:0]        line_cnt,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [8:0] H_LAST = 9'(H_ACTIVE - 1);
  localparam logic [8:0] V_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    WAIT_PIX,
    WAIT_DISP,
    FRAME_END
  } state_t;

  state_t state;
  state_t state_next;

  logic vs_prev;
  logic vs_edge;
  logic in_frame;
  logic last_pix;
  logic frame_start;
  logic accept;
  logic pix_finish;
  logic skip_frame;

  // A vs edge always beats a coincident pixel handshake or disp_done.
  assign vs_edge     = vs & ~vs_prev;
  assign in_frame    = (state == WAIT_PIX) || (state == WAIT_DISP);
  assign last_pix    = (pix_cnt == H_LAST) && (line_cnt == V_LAST);
  assign frame_start = init_comp & vs_edge & (in_frame | (state == WAIT_VS));
  assign accept      = init_comp & ~vs_edge & (state == WAIT_PIX) & bus.pix_valid;
  assign pix_finish  = (init_comp & ~vs_edge & (state == WAIT_DISP) & bus.disp_done)
                     | (accept & skip_frame);

`ifdef FRAME_SKIP_EN
  logic next_odd;
  logic odd_frame;

  // next_odd is the parity the upcoming frame will take, so the first frame is even.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      next_odd  <= 1'b0;
      odd_frame <= 1'b0;
    end else if (frame_start) begin
      odd_frame <= next_odd;
      next_odd  <= ~next_odd;
    end
  end

  assign skip_frame = odd_frame;
`else
  assign skip_frame = 1'b0;
`endif

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!init_comp) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = WAIT_VS;
        end
        WAIT_VS: begin
          if (vs_edge) begin
            state_next = WAIT_PIX;
          end
        end
        WAIT_PIX: begin
          if (vs_edge) begin
            state_next = WAIT_PIX;
          end else if (accept) begin
            if (!skip_frame) begin
              state_next = WAIT_DISP;
            end else if (last_pix) begin
              state_next = FRAME_END;
            end else begin
              state_next = WAIT_PIX;
            end
          end
        end
        WAIT_DISP: begin
          if (vs_edge) begin
            state_next = WAIT_PIX;
          end else if (bus.disp_done) begin
            state_next = last_pix ? FRAME_END : WAIT_PIX;
          end
        end
        FRAME_END: begin
          state_next = WAIT_VS;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // pix_ready is withheld on a vs edge or init drop so upstream never sees a dropped handshake.
  always_comb begin
    bus.pix_ready  = 1'b0;
    bus.disp_valid = 1'b0;
    frame_active   = 1'b0;
    frame_done     = 1'b0;
    case (state)
      WAIT_PIX: begin
        bus.pix_ready = init_comp & ~vs_edge;
        frame_active  = 1'b1;
      end
      WAIT_DISP: begin
        bus.disp_valid = 1'b1;
        frame_active   = 1'b1;
      end
      FRAME_END: begin
        frame_done = ~skip_frame;
      end
      default: begin
      end
    endcase
  end

  // The final pixel of a frame does not advance the counters, so FRAME_END shows its position.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      vs_prev       <= 1'b0;
      overrun       <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      bus.disp_data <= '0;
    end else begin
      vs_prev <= vs;

      if (init_comp && vs_edge && in_frame) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end

      if (!init_comp || frame_start) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (pix_finish && !last_pix) begin
        if (pix_cnt == H_LAST) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + 9'd1;
        end else begin
          pix_cnt <= pix_cnt + 9'd1;
        end
      end

      if (!init_comp) begin
        bus.disp_data <= '0;
      end else if (accept && !skip_frame) begin
        bus.disp_data <= bus.pix_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer at H_ACTIVE=4, V_ACTIVE=2; follows FRAME_SKIP_EN if defined.
`timescale 1ns/1ps
module tb_frame_sequencer;
  localparam int H = 4;
  localparam int V = 2;
`ifdef FRAME_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] data;
    logic [8:0]  pc;
    logic [8:0]  lc;
  } exp_t;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b0;
  logic       init_comp = 1'b0;
  logic       vs = 1'b0;
  logic       clr_err = 1'b0;
  logic       frame_active;
  logic       frame_done;
  logic       overrun;
  logic [8:0] pix_cnt;
  logic [8:0] line_cnt;

  frame_sequencer_if bus();

  frame_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .init_comp    (init_comp),
    .vs           (vs),
    .clr_err      (clr_err),
    .bus          (bus),
    .frame_active (frame_active),
    .pix_cnt      (pix_cnt),
    .line_cnt     (line_cnt),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk_50M = ~clk_50M;

  int          total = 0;
  int          bad = 0;
  int          fd_count = 0;
  int          fd_base = 0;
  int          frames_started = 0;
  exp_t        sb[$];
  logic        prev_valid = 1'b0;
  logic [23:0] held = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic vsPulse(input bit with_clr = 1'b0);
    vs = 1'b1;
    clr_err = with_clr;
    tick();
    vs = 1'b0;
    clr_err = 1'b0;
    frames_started++;
  endtask

  // mode 0: normal display, 1: disp_done together with a vs edge, 2: init_comp dropped in WAIT_DISP
  task automatic applyStimulus(input logic [23:0] data, input int pc, input int lc, input int mode);
    bit skip_now;
    int n;
    skip_now = SKIP && (frames_started > 0) && (((frames_started - 1) % 2) == 1);
    if (!skip_now) sb.push_back('{data: data, pc: 9'(pc), lc: 9'(lc)});
    bus.pix_data  = data;
    bus.pix_valid = 1'b1;
    n = 0;
    while (!bus.pix_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.pix_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL pix_ready_timeout: got 0, expected 1 within 20 cycles (data %0h)", data);
      bus.pix_valid = 1'b0;
      return;
    end
    if (skip_now) checkOutput("skip_pix_cnt", pix_cnt, pc);
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_data  = ~data;
    if (skip_now) begin
      checkOutput("skip_no_disp", bus.disp_valid, 0);
      return;
    end
    checkOutput("disp_latency", bus.disp_valid, 1);
    if (!bus.disp_valid) return;
    case (mode)
      1: begin
        tick(2);
        vs = 1'b1;
        bus.disp_done = 1'b1;
        tick();
        vs = 1'b0;
        bus.disp_done = 1'b0;
        frames_started++;
      end
      2: begin
        tick();
        init_comp = 1'b0;
        tick();
      end
      default: begin
        tick(2);
        bus.disp_done = 1'b1;
        tick();
        bus.disp_done = 1'b0;
      end
    endcase
  endtask

  // Monitor: each new disp_valid presentation pops one expectation; held data is checked every cycle.
  always @(negedge clk_50M) begin
    exp_t e;
    if (frame_done) fd_count <= fd_count + 1;
    if (bus.disp_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_unexpected_disp: got disp_data %0h, expected no display", bus.disp_data);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_disp_data", bus.disp_data, e.data);
        checkOutput("sb_pix_cnt", pix_cnt, e.pc);
        checkOutput("sb_line_cnt", line_cnt, e.lc);
        held <= e.data;
      end
    end else if (bus.disp_valid) begin
      checkOutput("disp_hold", bus.disp_data, held);
    end
    prev_valid <= bus.disp_valid;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.disp_done = 1'b0;
    rst       = 1'b0;
    init_comp = 1'b1;
    vs        = 1'b0;

    tick(2);
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    checkOutput("rst_pix_ready", bus.pix_ready, 0);
    checkOutput("rst_disp_valid", bus.disp_valid, 0);
    checkOutput("rst_frame_active", frame_active, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_pix_cnt", pix_cnt, 0);
    checkOutput("rst_line_cnt", line_cnt, 0);
    checkOutput("rst_disp_data", bus.disp_data, 0);

    rst = 1'b1;
    #2;
    checkOutput("release_frame_active", frame_active, 0);
    tick();
    checkOutput("wait_vs_ready", bus.pix_ready, 0);

    for (int f = 0; f < 3; f++) begin
      vsPulse();
      checkOutput("frame_active_rise", frame_active, 1);
      for (int p = 0; p < 8; p++) begin
        applyStimulus(24'(f * 16 + p + 1), p % 4, p / 4, 0);
      end
      checkOutput("frame_done_pulse", frame_done, (SKIP && f == 1) ? 0 : 1);
      checkOutput("frame_end_active", frame_active, 0);
      checkOutput("frame_end_pix", pix_cnt, 3);
      checkOutput("frame_end_line", line_cnt, 1);
      tick();
      checkOutput("frame_done_single", frame_done, 0);
    end
    checkOutput("frame_done_count", fd_count, SKIP ? 2 : 3);

    vsPulse();
    rst = 1'b0;
    #2;
    checkOutput("async_rst_active", frame_active, 0);
    checkOutput("async_rst_ready", bus.pix_ready, 0);
    tick();
    rst = 1'b1;
    frames_started = 0;
    tick();
    fd_base = fd_count;

    vsPulse();
    checkOutput("no_ovr_from_wait_vs", overrun, 0);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(24'(8'h21 + p), p % 4, p / 4, 0);
    end
    vsPulse();
    checkOutput("ovr_set", overrun, 1);
    checkOutput("ovr_pix_cnt", pix_cnt, 0);
    checkOutput("ovr_line_cnt", line_cnt, 0);
    checkOutput("ovr_frame_active", frame_active, 1);
    applyStimulus(24'h000026, 0, 0, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("clr_err", overrun, 0);
    vsPulse(1'b1);
    checkOutput("set_beats_clr", overrun, 1);

    applyStimulus(24'h000027, 0, 0, 0);
    applyStimulus(24'h000028, 1, 0, 1);
    checkOutput("coinc_pix_cnt", pix_cnt, 0);
    checkOutput("coinc_overrun", overrun, 1);
    checkOutput("coinc_disp_valid", bus.disp_valid, 0);
    checkOutput("coinc_pix_ready", bus.pix_ready, 1);

    vsPulse();
    applyStimulus(24'h000029, 0, 0, 0);
    applyStimulus(24'h00002A, 1, 0, 2);
    checkOutput("drop_disp_valid", bus.disp_valid, 0);
    checkOutput("drop_pix_ready", bus.pix_ready, 0);
    checkOutput("drop_frame_active", frame_active, 0);
    checkOutput("drop_pix_cnt", pix_cnt, 0);
    checkOutput("drop_disp_data", bus.disp_data, 0);
    checkOutput("drop_overrun_kept", overrun, 1);
    init_comp = 1'b1;
    tick();
    checkOutput("reinit_pix_ready", bus.pix_ready, 0);
    checkOutput("reinit_frame_active", frame_active, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("reinit_clr", overrun, 0);
    vsPulse();
    checkOutput("reinit_frame_start", frame_active, 1);
    checkOutput("reinit_no_ovr", overrun, 0);
    applyStimulus(24'h00002B, 0, 0, 0);

    tick(2);
    checkOutput("no_frame_done_phase_b", fd_count - fd_base, 0);
    checkOutput("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter H_ACTIVE, default 320, pixels per line.
REQ-002 Parameter V_ACTIVE, default 240, lines per frame.
REQ-003 clk_50M  in  1  single block clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 init_comp  in  1  camera SCCB initialisation complete, level.
REQ-006 vs  in  1  camera vertical sync, already in clk_50M domain; rising edge = frame start.
REQ-007 pix_valid  in  1  convolution pixel available.
REQ-008 pix_data  in  24  {red,green,blue} pixel.
REQ-009 pix_ready  out  1  sequencer accepts pixel this cycle.
REQ-010 disp_valid  out  1  pixel presented to TFT display controller.
REQ-011 disp_data  out  24  held pixel to display.
REQ-012 disp_done  in  1  one-cycle pulse: display consumed disp_data (colour load complete).
REQ-013 clr_err  in  1  synchronous clear of overrun.
REQ-014 frame_active  out  1  high between frame start and frame end.
REQ-015 pix_cnt  out  9  pixel index in current line.
REQ-016 line_cnt  out  9  line index in current frame.
REQ-017 frame_done  out  1  one-cycle pulse at frame completion.
REQ-018 overrun  out  1  sticky: vs edge arrived mid-frame.

Function
REQ-019 States IDLE, WAIT_VS, WAIT_PIX, WAIT_DISP, FRAME_END; vs edge = vs high and registered previous vs low.
REQ-020 IDLE: all handshakes low; init_comp=1 -> WAIT_VS.
REQ-021 WAIT_VS: pix_ready=0; vs edge -> WAIT_PIX, pix_cnt=line_cnt=0, frame_active=1.
REQ-022 WAIT_PIX: pix_ready=1; pix_valid&pix_ready -> disp_data<=pix_data, disp_valid=1 next cycle (1-cycle latency), -> WAIT_DISP.
REQ-023 WAIT_DISP: pix_ready=0; disp_valid and disp_data held stable until disp_done.
REQ-024 disp_done in WAIT_DISP: disp_valid=0 next cycle; pix_cnt wraps to 0 at H_ACTIVE-1 with line_cnt+1; after pixel (H_ACTIVE-1,V_ACTIVE-1) -> FRAME_END, else -> WAIT_PIX.
REQ-025 disp_done outside WAIT_DISP ignored; pix_valid while pix_ready=0 ignored (upstream holds data).
REQ-026 FRAME_END: frame_done=1 for one cycle, frame_active=0, counters held, -> WAIT_VS.
REQ-027 vs edge in WAIT_PIX/WAIT_DISP: overrun<=1, disp_valid<=0, counters cleared, -> WAIT_PIX (new frame); no frame_done.
REQ-028 vs edge coincident with disp_done: vs wins; pixel not counted.
REQ-029 init_comp low in any state -> IDLE next cycle, outputs to reset values; overrun retained.
REQ-030 clr_err clears overrun; simultaneous overrun set and clr_err: set wins.

Reset
REQ-031 rst low asynchronously forces IDLE; pix_ready, disp_valid, frame_active, frame_done, overrun = 0; disp_data, pix_cnt, line_cnt = 0; previous-vs register = 0.
REQ-032 Release of rst is sampled on the next clk_50M edge; no output change before.

Configuration
REQ-033 Macro FRAME_SKIP_EN defined: a frame-parity bit toggles at each frame start (reset 0, first frame even); odd frames run with pix_ready=1 throughout WAIT_PIX, pixels consumed and counted, disp_valid never asserted, frame_done suppressed.
REQ-034 FRAME_SKIP_EN undefined: every frame displayed per REQ-019..030; no parity logic.

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-035 rst low, init_comp=1, vs edge -> all outputs 0 until rst high; frame_active=1 one cycle after first vs edge.
REQ-036 8 pixels 0x000001..0x000008, disp_done 3 cycles after each disp_valid -> disp_data sequence matches, pix_cnt 0..3 twice, line_cnt 0->1, single frame_done after 8th disp_done.
REQ-037 vs edge after 5th pixel -> overrun=1, counters 0, next pixel shown with pix_cnt=0; clr_err -> overrun=0.
REQ-038 disp_done and vs edge same cycle -> pix_cnt not incremented, overrun=1.
REQ-039 init_comp dropped during WAIT_DISP -> IDLE, disp_valid=0 next cycle; reasserted -> WAIT_VS.
REQ-040 FRAME_SKIP_EN, three frames -> disp_valid active in frames 0 and 2 only, frame_done pulses twice.
